// File: rtl/key_lock_pkg.sv
// Shared definitions for the key sequence lock: FSM state encoding and
// active-low 7-segment patterns ordered {g,f,e,d,c,b,a}.
package key_lock_pkg;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StEntry = 3'd1,
        StOpen  = 3'd2,
        StFail  = 3'd3
    } lock_state_e;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_U     = 7'b1000001;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    function automatic logic [6:0] seg_digit(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = SEG_0;
            4'd1:    s = SEG_1;
            4'd2:    s = SEG_2;
            4'd3:    s = SEG_3;
            4'd4:    s = SEG_4;
            4'd5:    s = SEG_5;
            4'd6:    s = SEG_6;
            4'd7:    s = SEG_7;
            4'd8:    s = SEG_8;
            4'd9:    s = SEG_9;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/key_debouncer.sv
// One key: synchroniser chain, level debouncer and one-cycle press pulse
// on an accepted release-to-press transition.
module key_debouncer #(
    parameter int unsigned SYNC_STAGES     = 3,
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic key_ni,
    output logic press_o
);
    localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   acc_q, acc_d;
    logic                   arm_q, arm_d;
    logic                   press_q, press_d;
    logic                   level;

    assign level   = sync_q[SYNC_STAGES-1];
    assign press_o = press_q;

    // Until the key has been seen released for a full debounce window after
    // reset, it stays disarmed so a key held through reset yields no event.
    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], key_ni};
        cnt_d   = '0;
        acc_d   = acc_q;
        arm_d   = arm_q;
        press_d = 1'b0;
        if (!arm_q) begin
            if (level) begin
                if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                    arm_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end else if (level != acc_q) begin
            if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                acc_d   = level;
                press_d = ~level;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q  <= '1;
            cnt_q   <= '0;
            acc_q   <= 1'b1;
            arm_q   <= 1'b0;
            press_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            arm_q   <= arm_d;
            press_q <= press_d;
        end
    end

endmodule

// File: rtl/key_sequence_lock.sv
// Combination lock driven by debounced push-buttons: sequence FSM with
// inter-press timeout, timed fail display and HEX0 progress readout.
module key_sequence_lock
    import key_lock_pkg::*;
#(
    parameter int unsigned NUM_KEYS        = 3,
    parameter int unsigned SYNC_STAGES     = 3,
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned SEQ_LEN         = 4,
    parameter int unsigned KW              = (NUM_KEYS > 2) ? $clog2(NUM_KEYS) : 1,
    parameter logic [SEQ_LEN*KW-1:0] CODE  = {2'd0, 2'd1, 2'd0, 2'd2},
    parameter int unsigned TIMEOUT_CYCLES  = 250000000,
    parameter int unsigned FAIL_CYCLES     = 50000000
) (
    input  logic                CLOCK_50,
    input  logic                reset,
    input  logic [NUM_KEYS-1:0] KEY,
    output logic                unlocked,
    output logic                error,
    output logic [3:0]          progress,
    output logic [6:0]          HEX0
);
    logic [NUM_KEYS-1:0] press;
    lock_state_e         state_q, state_d;
    logic [3:0]          progress_q, progress_d;
    logic [31:0]         tmo_q, tmo_d;
    logic [31:0]         fail_q, fail_d;
    logic                unlocked_q, unlocked_d;
    logic                error_q, error_d;
    logic [3:0]          press_cnt;
    logic [KW-1:0]       press_idx;
    logic [KW-1:0]       exp_key;
    logic                any_press, good_press;

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
        key_debouncer #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_deb (
            .clk_i   (CLOCK_50),
            .rst_i   (reset),
            .key_ni  (KEY[k]),
            .press_o (press[k])
        );
    end

    // Multiple simultaneous presses never match, so they count as a wrong key.
    always_comb begin
        press_cnt = '0;
        press_idx = '0;
        for (int k = 0; k < NUM_KEYS; k++) begin
            if (press[k]) begin
                press_cnt = press_cnt + 4'd1;
                press_idx = KW'(k);
            end
        end
        exp_key = '0;
        for (int i = 0; i < SEQ_LEN; i++) begin
            if (progress_q == 4'(i)) exp_key = CODE[i*KW +: KW];
        end
        any_press  = |press;
        good_press = (press_cnt == 4'd1) && (press_idx == exp_key);
    end

    always_comb begin
        state_d    = state_q;
        progress_d = progress_q;
        tmo_d      = tmo_q;
        fail_d     = fail_q;
        case (state_q)
            StIdle: begin
                progress_d = '0;
                if (any_press) begin
                    tmo_d = '0;
                    if (!good_press) begin
                        state_d = StFail;
                        fail_d  = '0;
                    end else if (SEQ_LEN == 1) begin
                        state_d    = StOpen;
                        progress_d = 4'(SEQ_LEN);
                    end else begin
                        state_d    = StEntry;
                        progress_d = 4'd1;
                    end
                end
            end
            StEntry: begin
                if (any_press) begin
                    tmo_d = '0;
                    if (!good_press) begin
                        state_d    = StFail;
                        progress_d = '0;
                        fail_d     = '0;
                    end else begin
                        progress_d = progress_q + 4'd1;
                        if (progress_q + 4'd1 == 4'(SEQ_LEN)) state_d = StOpen;
                    end
                end else if (tmo_q == 32'(TIMEOUT_CYCLES - 1)) begin
                    state_d    = StIdle;
                    progress_d = '0;
                    tmo_d      = '0;
                end else begin
                    tmo_d = tmo_q + 32'd1;
                end
            end
            StOpen: begin
                if (any_press) begin
                    state_d    = StIdle;
                    progress_d = '0;
                end
            end
            StFail: begin
                progress_d = '0;
                if (fail_q == 32'(FAIL_CYCLES - 1)) begin
                    state_d = StIdle;
                    fail_d  = '0;
                end else begin
                    fail_d = fail_q + 32'd1;
                end
            end
            default: begin
                state_d    = StIdle;
                progress_d = '0;
                tmo_d      = '0;
                fail_d     = '0;
            end
        endcase
        unlocked_d = (state_d == StOpen);
        error_d    = (state_d == StFail) && (state_q != StFail);
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q    <= StIdle;
            progress_q <= '0;
            tmo_q      <= '0;
            fail_q     <= '0;
            unlocked_q <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            progress_q <= progress_d;
            tmo_q      <= tmo_d;
            fail_q     <= fail_d;
            unlocked_q <= unlocked_d;
            error_q    <= error_d;
        end
    end

    always_comb begin
        case (state_q)
            StIdle, StEntry: HEX0 = seg_digit(progress_q);
            StOpen:          HEX0 = SEG_U;
            StFail:          HEX0 = SEG_E;
            default:         HEX0 = SEG_BLANK;
        endcase
    end

    assign unlocked = unlocked_q;
    assign error    = error_q;
    assign progress = progress_q;

endmodule
